data_memory_lsu: RTL and testbench

Parametrised, handshaked data memory for the RISCV32i core's MEM stage. It replaces the fixed word-only data memory and adds:
- RV32I byte, halfword and word loads and stores, with sign or zero extension.
- A configurable number of wait states.
- Error reporting for misaligned, out-of-range and illegal accesses.

The pipeline issues one request at a time and stalls until the single-cycle response arrives.

---
 rtl/data_memory_lsu.sv | 215 +++++++++++++++++++++
 tb/tb_data_memory_lsu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_lsu.sv
// Handshaked RV32I data memory for the MEM stage: byte/half/word loads and stores,
// configurable wait states and error reporting for misaligned, out-of-range and illegal accesses.
module data_memory_lsu #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 0,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned Words    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WaitInit = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [Words];

  // With no wait states the commit edge is the acceptance edge, so the live request is used.
  logic        acc_we;
  logic [2:0]  acc_funct3;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;

  always_comb begin
    if (state_q == StIdle) begin
      acc_we     = req_we;
      acc_funct3 = req_funct3;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [1:0]            acc_off;

  assign acc_idx = acc_addr[DEPTH_LOG2+1:2];
  assign acc_off = acc_addr[1:0];

  logic err_range, err_align, err_funct, acc_err;

  always_comb begin
    err_range = (acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0;
    err_align = 1'b0;
    case (acc_funct3[1:0])
      2'b01:   err_align = acc_off[0];
      2'b10:   err_align = acc_off != 2'b00;
      default: err_align = 1'b0;
    endcase
    if (acc_we) begin
      err_funct = acc_funct3[2] || (acc_funct3[1:0] == 2'b11);
    end else begin
      err_funct = (acc_funct3 == 3'b011) || (acc_funct3[2:1] == 2'b11);
    end
    acc_err = err_range || err_align || err_funct;
  end

  logic [31:0] rd_word;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    rd_word = mem_q[acc_idx];
    ld_byte = 8'(rd_word >> {acc_off, 3'b000});
    ld_half = acc_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (acc_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = 32'd0;
    endcase
  end

  logic [3:0]  st_be;
  logic [31:0] st_data;

  // Store data is replicated across lanes; the byte enables pick the addressed ones.
  always_comb begin
    case (acc_funct3[1:0])
      2'b00: begin
        st_be   = 4'b0001 << acc_off;
        st_data = {4{acc_wdata[7:0]}};
      end
      2'b01: begin
        st_be   = acc_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  logic enter_resp;
  logic mem_we;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          if (LATENCY == 0) begin
            state_d    = StResp;
            enter_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d    = StResp;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_ready_d = (state_d == StIdle);
    rsp_valid_d = enter_resp;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    if (enter_resp) begin
      rsp_err_d   = acc_err;
      rsp_rdata_d = (acc_we || acc_err) ? 32'd0 : ld_data;
    end
  end

  // Reset on the commit edge suppresses the write.
  assign mem_we = enter_resp && rst && acc_we && !acc_err;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[acc_idx][i*8 +: 8] <= st_data[i*8 +: 8];
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// Directed bench for data_memory_lsu: one instance with no wait states, one with three.
module tb_data_memory_lsu;

  logic        clk;
  logic        rst_n  [2];
  logic        valid  [2];
  logic        we     [2];
  logic [2:0]  f3     [2];
  logic [31:0] addr   [2];
  logic [31:0] wdata  [2];
  logic        rdy    [2];
  logic        rv     [2];
  logic [31:0] rd     [2];
  logic        er     [2];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  data_memory_lsu #(.DEPTH_LOG2(10), .LATENCY(0)) u_dut0 (
    .clk        (clk),
    .rst        (rst_n[0]),
    .req_valid  (valid[0]),
    .req_ready  (rdy[0]),
    .req_we     (we[0]),
    .req_funct3 (f3[0]),
    .req_addr   (addr[0]),
    .req_wdata  (wdata[0]),
    .rsp_valid  (rv[0]),
    .rsp_rdata  (rd[0]),
    .rsp_err    (er[0])
  );

  data_memory_lsu #(.DEPTH_LOG2(10), .LATENCY(3)) u_dut3 (
    .clk        (clk),
    .rst        (rst_n[1]),
    .req_valid  (valid[1]),
    .req_ready  (rdy[1]),
    .req_we     (we[1]),
    .req_funct3 (f3[1]),
    .req_addr   (addr[1]),
    .req_wdata  (wdata[1]),
    .rsp_valid  (rv[1]),
    .rsp_rdata  (rd[1]),
    .rsp_err    (er[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d);
    check("rst_ready", 32'(rdy[d]), 32'd1);
    check("rst_valid", 32'(rv[d]), 32'd0);
    check("rst_rdata", rd[d], 32'd0);
    check("rst_err", 32'(er[d]), 32'd0);
  endtask

  // One complete access; fields are scrambled right after acceptance to prove they were latched.
  task automatic xact(input int d, input logic w, input logic [2:0] fn, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input string tag);
    int n;
    int lat;
    lat = (d == 0) ? 0 : 3;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(rdy[d]), 32'd1);
    valid[d] = 1'b1;
    we[d]    = w;
    f3[d]    = fn;
    addr[d]  = a;
    wdata[d] = wd;
    @(posedge clk);
    #1;
    valid[d] = 1'b0;
    we[d]    = ~w;
    f3[d]    = 3'b111;
    addr[d]  = 32'hFFFF_FFFC;
    wdata[d] = 32'h0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!rv[d]) check({tag, "_ready_wait"}, 32'(rdy[d]), 32'd0);
    end while (!rv[d] && n <= lat + 3);
    check({tag, "_latency"}, 32'(n), 32'(lat + 1));
    check({tag, "_ready_resp"}, 32'(rdy[d]), 32'd0);
    check({tag, "_rdata"}, rd[d], exp_rd);
    check({tag, "_err"}, 32'(er[d]), 32'(exp_err));
    @(negedge clk);
    check({tag, "_pulse"}, 32'(rv[d]), 32'd0);
    check({tag, "_ready_back"}, 32'(rdy[d]), 32'd1);
  endtask

  // SW on the slow instance with reset asserted a chosen number of negedges after acceptance.
  task automatic abort_store(input int lag, input string tag);
    int pulses;
    @(negedge clk);
    valid[1] = 1'b1;
    we[1]    = 1'b1;
    f3[1]    = 3'b010;
    addr[1]  = 32'h20;
    wdata[1] = 32'h1234_5678;
    @(posedge clk);
    #1;
    valid[1] = 1'b0;
    we[1]    = 1'b0;
    repeat (lag) @(negedge clk);
    rst_n[1] = 1'b0;
    @(negedge clk);
    check_reset_outputs(1);
    rst_n[1] = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (rv[1]) pulses++;
    end
    check({tag, "_no_rsp"}, 32'(pulses), 32'd0);
  endtask

  localparam logic [2:0] FB  = 3'b000;
  localparam logic [2:0] FH  = 3'b001;
  localparam logic [2:0] FW  = 3'b010;
  localparam logic [2:0] FBU = 3'b100;
  localparam logic [2:0] FHU = 3'b101;

  logic [2:0]  b2b_fn  [4];
  logic [31:0] b2b_adr [4];
  logic [31:0] b2b_exp [4];

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      valid[d] = 1'b0;
      we[d]    = 1'b0;
      f3[d]    = 3'b000;
      addr[d]  = 32'h0;
      wdata[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    // No wait states: basic store/load and lane handling.
    xact(0, 1'b1, FW, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw_10");
    xact(0, 1'b0, FW, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw_10");
    xact(0, 1'b1, FB, 32'h12, 32'hAAAA_AA55, 32'h0, 1'b0, "sb_12");
    xact(0, 1'b0, FW, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0, "lw_after_sb");
    xact(0, 1'b0, FB, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0, "lb_13");
    xact(0, 1'b0, FBU, 32'h13, 32'h0, 32'h0000_00DE, 1'b0, "lbu_13");
    xact(0, 1'b0, FH, 32'h10, 32'h0, 32'hFFFF_BEEF, 1'b0, "lh_10");
    xact(0, 1'b0, FHU, 32'h12, 32'h0, 32'h0000_DE55, 1'b0, "lhu_12");
    xact(0, 1'b0, FB, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0, "lb_10");
    xact(0, 1'b0, FBU, 32'h11, 32'h0, 32'h0000_00BE, 1'b0, "lbu_11");

    // Errors: none may touch the array.
    xact(0, 1'b0, FW, 32'h11, 32'h0, 32'h0, 1'b1, "lw_misaligned");
    xact(0, 1'b1, FH, 32'h13, 32'h1234, 32'h0, 1'b1, "sh_misaligned");
    xact(0, 1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_011");
    xact(0, 1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1, "ld_f3_110");
    xact(0, 1'b0, FW, 32'h1000, 32'h0, 32'h0, 1'b1, "lw_range");
    xact(0, 1'b1, FW, 32'h1010, 32'h0, 32'h0, 1'b1, "sw_range");
    xact(0, 1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, "st_f3_011");
    xact(0, 1'b1, FBU, 32'h10, 32'h0, 32'h0, 1'b1, "st_f3_100");
    xact(0, 1'b0, FW, 32'h10, 32'h0, 32'hDE55_BEEF, 1'b0, "lw_unchanged");

    xact(0, 1'b1, FH, 32'h12, 32'hFFFF_A5A5, 32'h0, 1'b0, "sh_12");
    xact(0, 1'b0, FW, 32'h10, 32'h0, 32'hA5A5_BEEF, 1'b0, "lw_after_sh");
    xact(0, 1'b0, FH, 32'h12, 32'h0, 32'hFFFF_A5A5, 1'b0, "lh_12");

    // Three wait states.
    xact(1, 1'b1, FW, 32'h20, 32'hCAFE_F00D, 32'h0, 1'b0, "l3_sw_20");
    xact(1, 1'b0, FW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, "l3_lw_20");
    abort_store(1, "abort_wait");
    xact(1, 1'b0, FW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, "l3_lw_after_wait_rst");
    abort_store(3, "abort_resp_edge");
    xact(1, 1'b0, FW, 32'h20, 32'h0, 32'hCAFE_F00D, 1'b0, "l3_lw_after_edge_rst");

    // Four loads with req_valid held high throughout.
    b2b_fn[0] = FB;  b2b_adr[0] = 32'h21; b2b_exp[0] = 32'hFFFF_FFF0;
    b2b_fn[1] = FHU; b2b_adr[1] = 32'h22; b2b_exp[1] = 32'h0000_CAFE;
    b2b_fn[2] = FH;  b2b_adr[2] = 32'h20; b2b_exp[2] = 32'hFFFF_F00D;
    b2b_fn[3] = FW;  b2b_adr[3] = 32'h20; b2b_exp[3] = 32'hCAFE_F00D;
    @(negedge clk);
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          int nd;
          we[1]    = 1'b0;
          f3[1]    = b2b_fn[k];
          addr[1]  = b2b_adr[k];
          valid[1] = 1'b1;
          nd = 0;
          while (!rdy[1] && nd < 40) begin
            @(negedge clk);
            nd++;
          end
          @(posedge clk);
          #1;
        end
        valid[1] = 1'b0;
      end
      begin
        int last_cyc;
        last_cyc = 0;
        for (int k = 0; k < 4; k++) begin
          int nm;
          nm = 0;
          while (!rv[1] && nm < 40) begin
            @(negedge clk);
            nm++;
          end
          check("b2b_pulse_seen", 32'(rv[1]), 32'd1);
          check("b2b_rdata", rd[1], b2b_exp[k]);
          check("b2b_err", 32'(er[1]), 32'd0);
          if (k > 0) check("b2b_spacing", 32'(cyc - last_cyc), 32'd5);
          last_cyc = cyc;
          @(negedge clk);
        end
      end
    join
    begin
      int extra;
      extra = 0;
      repeat (12) begin
        @(negedge clk);
        if (rv[1]) extra++;
      end
      check("b2b_extra_pulses", 32'(extra), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
